mem_lsu: RTL and testbench

- Load/store unit for the MEM stage of the 5-stage RV32I pipeline.
- Consumes the EX/MEM register outputs (ALUResultM, WriteDataM, RdM-stage control) and produces ReadDataM for the MEM/WB register.
- Drives a word-addressed data bus with a req/ack handshake, byte-lane strobes and sign/zero extension.
- Raises StallM while an access is outstanding so the hazard unit can freeze stages F–M.

---
 rtl/mem_lsu.sv | 199 +++++++++++++++++++
 tb/tb_mem_lsu.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Issues one word-addressed bus access per
// load/store, holds the pipeline until it completes, extends load data, and
// reports misaligned/illegal accesses and bus errors/timeouts.
module mem_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        AccessFaultM,
   output logic        BusErrM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   // Last REQ cycle index; counter starts at 0 on entry so bus_req is high
   // for exactly TIMEOUT_CYCLES cycles before abort.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] rdata_q, rdata_d;
   logic        buserr_q, buserr_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;

   logic        f3_legal, aligned, acc_ok, acc_bad;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [31:0] rd_shift;
   logic [15:0] rd_half;
   logic [31:0] rd_ext;
   logic        stall_c, fault_c;

   // Decode legality and byte-lane pattern of the access on the inputs
   always_comb begin
      f3_legal = 1'b0;
      case (Funct3M)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = MemReadM;
         default:                f3_legal = 1'b0;
      endcase
      aligned = 1'b1;
      case (Funct3M[1:0])
         2'b01:   aligned = ~ALUResultM[0];
         2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      acc_ok  = (MemReadM ^ MemWriteM) & f3_legal & aligned;
      acc_bad = (MemReadM | MemWriteM) & ~acc_ok;
      case (Funct3M[1:0])
         2'b00: begin
            be_c    = 4'b0001 << ALUResultM[1:0];
            wdata_c = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            be_c    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{WriteDataM[15:0]}};
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = WriteDataM;
         end
      endcase
   end

   // Select and extend the returned word using the latched width and offset
   always_comb begin
      rd_shift = bus_rdata >> {off_q, 3'b000};
      rd_half  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (f3_q)
         3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
         3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
         3'b101:  rd_ext = {16'd0, rd_half};
         default: rd_ext = bus_rdata;
      endcase
   end

   // Next-state logic for the IDLE -> REQ -> DONE access sequence
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      rdata_d     = rdata_q;
      buserr_d    = 1'b0;
      f3_d        = f3_q;
      off_d       = off_q;
      stall_c     = 1'b0;
      fault_c     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (acc_ok) begin
               stall_c     = 1'b1;
               bus_req_d   = 1'b1;
               bus_we_d    = MemWriteM;
               bus_addr_d  = {ALUResultM[31:2], 2'b00};
               bus_be_d    = be_c;
               bus_wdata_d = wdata_c;
               f3_d        = Funct3M;
               off_d       = ALUResultM[1:0];
               cnt_d       = 16'd0;
               state_d     = S_REQ;
            end else if (acc_bad) begin
               fault_c = 1'b1;
            end
         end
         S_REQ: begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            if (bus_ack) begin
               bus_req_d = 1'b0;
               state_d   = S_DONE;
               if (bus_err) begin
                  buserr_d = 1'b1;
                  if (!bus_we_q) rdata_d = 32'd0;
               end else if (!bus_we_q) begin
                  rdata_d = rd_ext;
               end
            end else if (cnt_q == TMO_LAST) begin
               bus_req_d = 1'b0;
               buserr_d  = 1'b1;
               if (!bus_we_q) rdata_d = 32'd0;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            // Instruction is still on the inputs; let the pipeline advance once.
            state_d = S_IDLE;
            cnt_d   = 16'd0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any in-flight access
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 16'd0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= 32'd0;
         bus_wdata_q <= 32'd0;
         bus_be_q    <= 4'd0;
         rdata_q     <= 32'd0;
         buserr_q    <= 1'b0;
         f3_q        <= 3'd0;
         off_q       <= 2'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         rdata_q     <= rdata_d;
         buserr_q    <= buserr_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
      end
   end

   // Combinational flags are forced low while reset is held
   assign StallM       = stall_c & ~reset;
   assign AccessFaultM = fault_c & ~reset;
   assign ReadDataM    = rdata_q;
   assign BusErrM      = buserr_q;
   assign bus_req      = bus_req_q;
   assign bus_we       = bus_we_q;
   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
   assign bus_be       = bus_be_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed + randomized checks of mem_lsu against a behavioural
// model of legality, lane selection, load extension and access timing.
module tb_mem_lsu;

   localparam int TMO = 4;

   logic        clk, reset;
   logic        MemReadM, MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic [31:0] ReadDataM;
   logic        StallM, AccessFaultM, BusErrM;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack, bus_err;
   logic [31:0] bus_rdata;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_rd = 32'd0;

   mem_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
      .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
      .ReadDataM(ReadDataM), .StallM(StallM), .AccessFaultM(AccessFaultM),
      .BusErrM(BusErrM), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
      .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference load result: pick the addressed byte/half/word, then extend
   function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      int sz;
      logic [31:0] mask, v;
      sz   = 1 << f3[1:0];
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v    = (w >> (8 * off)) & mask;
      if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
      return v;
   endfunction

   task automatic idle_inputs();
      MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'd0;
      ALUResultM = 32'd0; WriteDataM = 32'd0;
   endtask

   // One instruction in MEM. dly = REQ cycle (1-based) carrying bus_ack; dly > TMO never acks.
   task automatic do_acc(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int dly, input logic err, input logic [31:0] rdat);
      int sz, n_req, n_stall, n_exp;
      logic legal, valid, done, stable_ok, acked;
      logic [3:0] e_be;
      logic [31:0] e_wd;
      sz    = 1 << f3[1:0];
      legal = rd ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
                 : (f3 <= 3'd2);
      valid = (rd ^ wr) && legal && ((a[1:0] % sz) == 0);
      e_be  = 4'(((1 << sz) - 1) << a[1:0]);
      e_wd  = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;

      @(negedge clk);
      MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = wd;
      bus_ack = 1'b0; bus_err = 1'b0;
      #1;
      chk("stall_issue", {31'd0, StallM}, {31'd0, valid});
      chk("fault", {31'd0, AccessFaultM}, {31'd0, !valid && (rd || wr)});
      if (!valid) begin
         @(posedge clk);
         @(negedge clk);
         chk("noreq_illegal", {31'd0, bus_req}, 32'd0);
         chk("rd_hold_illegal", ReadDataM, exp_rd);
         idle_inputs();
         return;
      end
      @(posedge clk);
      n_req = 0; n_stall = 1; done = 1'b0; stable_ok = 1'b1; acked = 1'b0;
      for (int k = 1; k <= TMO + 1 && !done; k++) begin
         @(negedge clk);
         if (bus_req) n_req++;
         if (StallM) n_stall++;
         if (bus_addr !== {a[31:2], 2'b00} || bus_be !== e_be || bus_we !== wr ||
             (wr && bus_wdata !== e_wd)) stable_ok = 1'b0;
         bus_ack   = (k == dly);
         bus_err   = (k == dly) && err;
         bus_rdata = (k == dly) ? rdat : $urandom;
         @(posedge clk);
         if (k == dly) acked = 1'b1;
         if (k == dly || k == TMO) done = 1'b1;
      end
      n_exp = (dly <= TMO) ? dly : TMO;
      if (rd) exp_rd = (!acked || err) ? 32'd0 : ld_model(f3, a[1:0], rdat);
      @(negedge clk);
      // Spurious ack in DONE must be ignored
      bus_ack = 1'b1; bus_err = 1'b0; bus_rdata = $urandom;
      chk("bus_fields", {31'd0, stable_ok}, 32'd1);
      chk("req_cycles", n_req, n_exp);
      chk("stall_cycles", n_stall, 1 + n_exp);
      chk("done_stall", {31'd0, StallM}, 32'd0);
      chk("done_req", {31'd0, bus_req}, 32'd0);
      chk("buserr", {31'd0, BusErrM}, {31'd0, (!acked || err)});
      chk("rdata", ReadDataM, exp_rd);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      bus_ack = 1'b0;
      #1;
      chk("post_buserr", {31'd0, BusErrM}, 32'd0);
      chk("post_req", {31'd0, bus_req}, 32'd0);
      chk("post_stall", {31'd0, StallM}, 32'd0);
      chk("post_rdata", ReadDataM, exp_rd);
   endtask

   initial begin
      logic [2:0] f3;
      logic rd, wr;
      int r;
      reset = 1'b1; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
      idle_inputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rdata", ReadDataM, 32'd0);
      chk("rst_outs", {26'd0, StallM, AccessFaultM, BusErrM, bus_req, bus_we, 1'b0}, 32'd0);
      chk("rst_bus", bus_addr | bus_wdata | {28'd0, bus_be}, 32'd0);
      reset = 1'b0;

      // Directed cases
      do_acc(1, 0, 3'b010, 32'h100, 0, 1, 0, 32'hDEADBEEF);
      chk("lw_const", ReadDataM, 32'hDEADBEEF);
      do_acc(1, 0, 3'b000, 32'h103, 0, 2, 0, 32'h80112233);
      chk("lb_const", ReadDataM, 32'hFFFFFF80);
      do_acc(1, 0, 3'b100, 32'h103, 0, 1, 0, 32'h80112233);
      chk("lbu_const", ReadDataM, 32'h00000080);
      do_acc(1, 0, 3'b101, 32'h102, 0, 3, 0, 32'h80112233);
      chk("lhu_const", ReadDataM, 32'h00008011);
      do_acc(0, 1, 3'b000, 32'h201, 32'h000000A5, 1, 0, 0);
      chk("sb_be", {28'd0, bus_be}, 32'h2);
      chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
      chk("sb_addr", bus_addr, 32'h200);
      do_acc(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 2, 0, 0);
      chk("sh_be", {28'd0, bus_be}, 32'hC);
      do_acc(1, 0, 3'b010, 32'h102, 0, 1, 0, 0);
      do_acc(0, 1, 3'b001, 32'h301, 0, 1, 0, 0);
      do_acc(1, 0, 3'b011, 32'h400, 0, 1, 0, 0);
      do_acc(1, 1, 3'b010, 32'h400, 0, 1, 0, 0);
      do_acc(1, 0, 3'b000, 32'h101, 0, 1, 0, 32'h0000AA00);
      do_acc(1, 0, 3'b010, 32'h500, 0, TMO + 5, 0, 0);
      chk("tmo_rdata", ReadDataM, 32'd0);
      do_acc(1, 0, 3'b010, 32'h100, 0, 1, 0, 32'h13579BDF);
      do_acc(1, 0, 3'b010, 32'h600, 0, 2, 1, 32'hFFFFFFFF);
      chk("err_rdata", ReadDataM, 32'd0);

      // Randomized mix, including illegal encodings, errors and timeouts
      for (int i = 0; i < 60; i++) begin
         r  = $urandom_range(0, 9);
         rd = (r == 0) || (r >= 5);
         wr = (r <= 4);
         f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                          : (rd ? 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2)
                                                : 3'($urandom_range(0, 2)));
         do_acc(rd, wr, f3, $urandom, $urandom, $urandom_range(1, TMO + 1),
                ($urandom_range(0, 7) == 0), $urandom);
      end

      // Reset during REQ aborts the access at once
      @(negedge clk);
      MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h700;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_req_drop", {31'd0, bus_req}, 32'd0);
      chk("rst_stall_drop", {31'd0, StallM}, 32'd0);
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      r = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus_req || StallM) r++;
      end
      chk("no_resume", r, 0);
      chk("rst_rdata2", ReadDataM, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
